result_streamer: RTL and testbench
==================================

RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter: n, default 8, matrix dimension; legal values are powers of two, 2..256.
REQ-002 Parameter: W, default 32, element width in bits.
REQ-003 Local: IW = $clog2(n), the index width.
REQ-004 Port: clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: wr_en  in  1  load strobe from the multiplier array.
REQ-007 Port: wr_i, wr_j  in  IW each  row and column of the element being loaded.
REQ-008 Port: wr_data  in  W  element value being loaded.
REQ-009 Port: start  in  1  request to stream the whole matrix.
REQ-010 Port: value  out  W  current element presented to the file writer.
REQ-011 Port: value_stb  out  1  high while value is valid.
REQ-012 Port: value_ack  in  1  writer accepts value.
REQ-013 Port: i, j  out  IW each  row and column of the element currently in flight.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  one-cycle pulse after the last element is accepted.

Function
REQ-016 Storage SHALL be n*n words of W bits, addressed row-major as i*n+j, with a synchronous read of 1-cycle latency; storage is not cleared by rst.
REQ-017 The FSM SHALL have four states: IDLE, FETCH, SEND, DONE.
REQ-018 In IDLE with wr_en=1, mem[wr_i][wr_j] <= wr_data at the clock edge; wr_en SHALL be ignored in every other state.
REQ-019 In IDLE with start=1: i<=0, j<=0, state<=FETCH; start SHALL be ignored in every other state.
REQ-020 If wr_en and start are both high in IDLE, the write SHALL complete and the written value SHALL be visible to the first FETCH.
REQ-021 FETCH (one cycle): value<=mem[i][j], value_stb<=1, state<=SEND.
REQ-022 SEND: value, i and j SHALL be held stable while value_stb=1 and value_ack=0, for an unbounded number of cycles.
REQ-023 A transfer occurs on the edge where value_stb=1 and value_ack=1; on that edge value_stb<=0.
REQ-024 On a transfer with j<n-1: j<=j+1 and state<=FETCH.
REQ-025 On a transfer with j=n-1 and i<n-1: j<=0, i<=i+1 and state<=FETCH.
REQ-026 On a transfer with i=n-1 and j=n-1: state<=DONE.
REQ-027 DONE (one cycle): done=1 and state<=IDLE; i and j keep their final values (n-1).
REQ-028 value_ack while value_stb=0 SHALL be ignored.
REQ-029 Exactly n*n transfers per start, in row-major order; no element is skipped or duplicated.
REQ-030 Latency: start sampled at edge k gives value_stb=1 after edge k+2; with ack held high, one element per 2 cycles; done is high after edge 2*n*n+1 relative to k.
REQ-031 value is not modified outside FETCH.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, value_stb=0, done=0, busy=0, i=0, j=0, value=0, regardless of clk.
REQ-033 rst asserted mid-stream SHALL abort the stream; no further transfers occur, and a new start after release restarts from (0,0) with the memory contents intact.

Verification
REQ-034 Load mem[r][c]=r*n+c (n=8), start, ack tied high -> 64 transfers with values 0..63 in order, done pulses once, busy high from start+1 through DONE.
REQ-035 Random ack stalls of 0-5 cycles -> value, i and j stable during each stall; sequence identical to REQ-034.
REQ-036 start pulsed during SEND and wr_en=1 with wr_data=0xDEAD during SEND -> no restart, no memory change, stream unaffected.
REQ-037 wr_en to (0,0) with 0xA5A5A5A5 in the same cycle as start -> first value=0xA5A5A5A5.
REQ-038 rst during element (3,5) -> value_stb=0 and busy=0 asynchronously; a later start streams from (0,0) with the prior data.
REQ-039 n=2, ack tied high -> 4 transfers, done is high after edge k+9 relative to start edge k.

Source files
------------

// File: rtl/result_streamer_if.sv
// Purpose : bundle of load, start and element-stream signals between the result
//           buffer, the multiplier array (loader) and the file writer (consumer).
// Ports   : wr_en/wr_i/wr_j/wr_data load port, start request, value/value_stb/
//           value_ack element handshake, i/j element index, busy/done status.
// Modports: master = result_streamer side, slave = loader/writer side.
interface result_streamer_if #(
  parameter int n = 8,
  parameter int W = 32
);
  localparam int IW = $clog2(n);

  logic          wr_en;
  logic [IW-1:0] wr_i;
  logic [IW-1:0] wr_j;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [W-1:0]  value;
  logic          value_stb;
  logic          value_ack;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic          busy;
  logic          done;

  modport master (
    input  wr_en, wr_i, wr_j, wr_data, start, value_ack,
    output value, value_stb, i, j, busy, done
  );

  modport slave (
    output wr_en, wr_i, wr_j, wr_data, start, value_ack,
    input  value, value_stb, i, j, busy, done
  );
endinterface

// File: rtl/result_streamer.sv
// Purpose     : n x n result buffer, loaded element-wise while idle, then streamed
//               row-major to a writer one element per value_stb/value_ack transfer.
// Latency     : start at edge k -> value_stb after edge k+2; 2 cycles per element
//               with ack held high; done pulse after edge k+2*n*n+1.
// Backpressure: value, i and j hold while value_stb=1 and value_ack=0, indefinitely.
// Ports       : clk, rst (async, active-high); bus (result_streamer_if.master)
//               carrying the load port, start, element handshake, index, busy, done.
module result_streamer #(
  parameter int n = 8,
  parameter int W = 32
) (
  input logic               clk,
  input logic               rst,
  result_streamer_if.master bus
);
  localparam int              IW   = $clog2(n);
  localparam int              AW   = 2 * IW;
  localparam logic [IW-1:0]   LAST = IW'(n - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [W-1:0]  mem [n*n];
  logic [W-1:0]  rd_data;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic [W-1:0]  value_q;
  logic          rd_ok;
  logic          xfer;
  logic          last_col;
  logic          last_row;

  assign xfer     = (state == SEND) && bus.value_ack;
  assign last_col = (col == LAST);
  assign last_row = (row == LAST);

  // Read address looks ahead on a transfer edge so rd_data already holds the
  // next element when FETCH begins, giving one FETCH cycle per element.
  always_comb begin
    rd_addr = {row, col};
    if (xfer && !last_col) begin
      rd_addr = {row, col + IW'(1)};
    end else if (xfer && !last_row) begin
      rd_addr = {row + IW'(1), {IW{1'b0}}};
    end
  end

  // Storage: row-major i*n+j, registered read, not cleared by reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.wr_en) begin
      mem[{bus.wr_i, bus.wr_j}] <= bus.wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = FETCH;
      FETCH: if (rd_ok) state_nxt = SEND;
      SEND:  if (bus.value_ack) state_nxt = (last_row && last_col) ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.value_stb = (state == SEND);
  end

  // Index and value registers. The first FETCH after start spends one extra
  // cycle re-reading (0,0): a load on the start edge lands in storage on that
  // same edge, so the lookahead read issued then would return the stale word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      value_q <= '0;
      rd_ok   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            row   <= '0;
            col   <= '0;
            rd_ok <= 1'b0;
          end
        end
        FETCH: begin
          if (rd_ok) begin
            value_q <= rd_data;
          end else begin
            rd_ok <= 1'b1;
          end
        end
        SEND: begin
          if (bus.value_ack) begin
            rd_ok <= 1'b1;
            if (!last_col) begin
              col <= col + IW'(1);
            end else if (!last_row) begin
              col <= '0;
              row <= row + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.value = value_q;
  assign bus.i     = row;
  assign bus.j     = col;
endmodule

// File: tb/tb_result_streamer.sv
// Purpose : directed self-checking bench for result_streamer (n=8 and n=2 instances).
// Timing  : inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: exercised with ack tied high, random 0-5 cycle stalls, and mid-stream reset.
module tb_result_streamer;
  localparam int N8 = 8;
  localparam int N2 = 2;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  result_streamer_if #(.n(N8), .W(W)) b8 ();
  result_streamer_if #(.n(N2), .W(W)) b2 ();

  result_streamer #(.n(N8), .W(W)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  result_streamer #(.n(N2), .W(W)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp2 [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b8.wr_en = 1'b0; b8.wr_i = '0; b8.wr_j = '0; b8.wr_data = '0;
    b8.start = 1'b0; b8.value_ack = 1'b0;
    b2.wr_en = 1'b0; b2.wr_i = '0; b2.wr_j = '0; b2.wr_data = '0;
    b2.start = 1'b0; b2.value_ack = 1'b0;
  endtask

  // mem[r][c] = r*8+c
  task automatic load8();
    for (int r = 0; r < N8; r++) begin
      for (int c = 0; c < N8; c++) begin
        b8.wr_en = 1'b1; b8.wr_i = 3'(r); b8.wr_j = 3'(c); b8.wr_data = W'(r * N8 + c);
        tick();
      end
    end
    b8.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    compared++; if (b8.value_stb !== 1'b0) begin mismatched++; $display("FAIL reset_stb: got %b expected 0", b8.value_stb); end
    compared++; if (b8.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", b8.busy); end
    compared++; if (b8.done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", b8.done); end
    compared++; if (b8.i !== 3'd0) begin mismatched++; $display("FAIL reset_i: got %0d expected 0", b8.i); end
    compared++; if (b8.j !== 3'd0) begin mismatched++; $display("FAIL reset_j: got %0d expected 0", b8.j); end
    compared++; if (b8.value !== 32'h0) begin mismatched++; $display("FAIL reset_value: got %0h expected 0", b8.value); end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_stream_acked();
    int first_stb = -1, done_cyc = -1, done_cnt = 0, n_xfer = 0, busy_bad = 0;
    logic [2:0] di = '0, dj = '0;
    b8.value_ack = 1'b1; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done_cyc < 0 && b8.busy !== 1'b1) busy_bad++;
      if (b8.value_stb === 1'b1) begin
        if (first_stb < 0) first_stb = c;
        compared++;
        if (b8.value !== W'(n_xfer) || b8.i !== 3'(n_xfer / 8) || b8.j !== 3'(n_xfer % 8)) begin
          mismatched++;
          $display("FAIL acked_elem%0d: got value=%0h i=%0d j=%0d expected value=%0h i=%0d j=%0d",
                   n_xfer, b8.value, b8.i, b8.j, n_xfer, n_xfer / 8, n_xfer % 8);
        end
        n_xfer++;
      end
      if (b8.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; di = b8.i; dj = b8.j; end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      tick();
    end
    compared++; if (first_stb != 2) begin mismatched++; $display("FAIL acked_first_stb_cycle: got %0d expected 2", first_stb); end
    compared++; if (n_xfer != 64) begin mismatched++; $display("FAIL acked_xfer_count: got %0d expected 64", n_xfer); end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL acked_done_pulses: got %0d expected 1", done_cnt); end
    compared++; if (done_cyc != 129) begin mismatched++; $display("FAIL acked_done_cycle: got %0d expected 129", done_cyc); end
    compared++; if (busy_bad != 0) begin mismatched++; $display("FAIL acked_busy_low_cycles: got %0d expected 0", busy_bad); end
    compared++; if (di !== 3'd7 || dj !== 3'd7) begin mismatched++; $display("FAIL acked_final_ij: got %0d,%0d expected 7,7", di, dj); end
    compared++; if (b8.busy !== 1'b0) begin mismatched++; $display("FAIL acked_busy_after: got %b expected 0", b8.busy); end
    b8.value_ack = 1'b0;
  endtask

  task automatic test_stalls();
    int got = 0, stall = 0, unstable = 0, stalls_seen = 0;
    bit inel = 1'b0;
    logic [W-1:0] hv = '0;
    logic [2:0] hi = '0, hj = '0;
    b8.value_ack = 1'b0; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    for (int c = 0; c < 2000 && got < 64; c++) begin
      if (b8.value_stb === 1'b1) begin
        if (!inel) begin
          inel = 1'b1; hv = b8.value; hi = b8.i; hj = b8.j;
          compared++;
          if (hv !== W'(got) || hi !== 3'(got / 8) || hj !== 3'(got % 8)) begin
            mismatched++;
            $display("FAIL stall_elem%0d: got value=%0h i=%0d j=%0d expected value=%0h i=%0d j=%0d",
                     got, hv, hi, hj, got, got / 8, got % 8);
          end
          stall = $urandom_range(0, 5);
        end else begin
          stalls_seen++;
          if (b8.value !== hv || b8.i !== hi || b8.j !== hj) unstable++;
        end
        if (stall == 0) begin
          b8.value_ack = 1'b1; got++; inel = 1'b0;
        end else begin
          stall--; b8.value_ack = 1'b0;
        end
      end else begin
        // ack with no strobe must be ignored
        b8.value_ack = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    b8.value_ack = 1'b0;
    compared++; if (got != 64) begin mismatched++; $display("FAIL stall_xfer_count: got %0d expected 64", got); end
    compared++; if (unstable != 0) begin mismatched++; $display("FAIL stall_unstable_cycles: got %0d expected 0 (of %0d)", unstable, stalls_seen); end
    compared++; if (b8.done !== 1'b1) begin mismatched++; $display("FAIL stall_done: got %b expected 1", b8.done); end
    tick();
    compared++; if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin mismatched++; $display("FAIL stall_idle_after: got busy=%b done=%b expected 0 0", b8.busy, b8.done); end
  endtask

  task automatic test_ignore();
    int done_cyc = -1, done_cnt = 0, n_xfer = 0, seq_bad = 0;
    b8.value_ack = 1'b1; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      b8.start = 1'b0; b8.wr_en = 1'b0;
      if (b8.value_stb === 1'b1) begin
        if (b8.value !== W'(n_xfer) || b8.i !== 3'(n_xfer / 8) || b8.j !== 3'(n_xfer % 8)) seq_bad++;
        n_xfer++;
        if (n_xfer >= 10 && n_xfer <= 20) begin
          // hit the SEND edge with a start and a write to the last element
          b8.start = 1'b1; b8.wr_en = 1'b1; b8.wr_i = 3'd7; b8.wr_j = 3'd7; b8.wr_data = 32'hDEAD;
        end
      end
      if (b8.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      tick();
    end
    b8.start = 1'b0; b8.wr_en = 1'b0; b8.value_ack = 1'b0;
    compared++; if (seq_bad != 0) begin mismatched++; $display("FAIL ignore_sequence_errors: got %0d expected 0", seq_bad); end
    compared++; if (n_xfer != 64) begin mismatched++; $display("FAIL ignore_xfer_count: got %0d expected 64", n_xfer); end
    compared++; if (done_cyc != 129) begin mismatched++; $display("FAIL ignore_done_cycle: got %0d expected 129", done_cyc); end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL ignore_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int stray = 0, n_xfer = 0, seq_bad = 0, done_cyc = -1, first_stb = -1;
    b8.value_ack = 1'b1; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b8.value_stb === 1'b1 && b8.i === 3'd3 && b8.j === 3'd5) begin found = 1'b1; break; end
      tick();
    end
    b8.value_ack = 1'b0;
    compared++; if (found != 1'b1) begin mismatched++; $display("FAIL abort_reach_3_5: got %0d expected 1", found); end
    #2 rst = 1'b1;
    #1;
    compared++; if (b8.value_stb !== 1'b0 || b8.busy !== 1'b0) begin mismatched++; $display("FAIL abort_async: got stb=%b busy=%b expected 0 0", b8.value_stb, b8.busy); end
    compared++; if (b8.i !== 3'd0 || b8.j !== 3'd0 || b8.value !== 32'h0) begin mismatched++; $display("FAIL abort_regs: got i=%0d j=%0d value=%0h expected 0 0 0", b8.i, b8.j, b8.value); end
    tick();
    @(negedge clk) rst = 1'b0;
    b8.value_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (b8.value_stb !== 1'b0 || b8.busy !== 1'b0) stray++;
    end
    compared++; if (stray != 0) begin mismatched++; $display("FAIL abort_stray_activity: got %0d expected 0", stray); end
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b8.value_stb === 1'b1) begin
        if (first_stb < 0) first_stb = c;
        if (b8.value !== W'(n_xfer) || b8.i !== 3'(n_xfer / 8) || b8.j !== 3'(n_xfer % 8)) seq_bad++;
        n_xfer++;
      end
      if (b8.done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0) break;
      tick();
    end
    tick();
    b8.value_ack = 1'b0;
    compared++; if (first_stb != 2) begin mismatched++; $display("FAIL abort_restart_first_cycle: got %0d expected 2", first_stb); end
    compared++; if (seq_bad != 0 || n_xfer != 64) begin mismatched++; $display("FAIL abort_restart_stream: got %0d errors %0d xfers expected 0 errors 64 xfers", seq_bad, n_xfer); end
    compared++; if (done_cyc != 129) begin mismatched++; $display("FAIL abort_restart_done_cycle: got %0d expected 129", done_cyc); end
  endtask

  task automatic test_write_start();
    int done_cyc = -1;
    b8.wr_en = 1'b1; b8.wr_i = 3'd0; b8.wr_j = 3'd0; b8.wr_data = 32'hA5A5A5A5;
    b8.start = 1'b1; b8.value_ack = 1'b1;
    tick();
    b8.wr_en = 1'b0; b8.start = 1'b0;
    tick();
    compared++; if (b8.value_stb !== 1'b0) begin mismatched++; $display("FAIL wrstart_stb_c1: got %b expected 0", b8.value_stb); end
    tick();
    compared++; if (b8.value_stb !== 1'b1 || b8.value !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL wrstart_first_value: got stb=%b value=%0h expected 1 a5a5a5a5", b8.value_stb, b8.value); end
    tick();
    tick();
    compared++; if (b8.value_stb !== 1'b1 || b8.value !== 32'h1) begin mismatched++; $display("FAIL wrstart_second_value: got stb=%b value=%0h expected 1 1", b8.value_stb, b8.value); end
    for (int c = 4; c < 200; c++) begin
      if (b8.done === 1'b1) begin done_cyc = c; break; end
      tick();
    end
    compared++; if (done_cyc != 129) begin mismatched++; $display("FAIL wrstart_done_cycle: got %0d expected 129", done_cyc); end
    b8.value_ack = 1'b0;
    tick();
  endtask

  task automatic test_n2();
    int done_cyc = -1, done_cnt = 0, n_xfer = 0, first_stb = -1;
    logic di = 1'b0, dj = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b2.wr_en = 1'b1; b2.wr_i = 1'(k / 2); b2.wr_j = 1'(k % 2); b2.wr_data = exp2[k];
      tick();
    end
    b2.wr_en = 1'b0;
    b2.value_ack = 1'b1; b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b2.value_stb === 1'b1) begin
        if (first_stb < 0) first_stb = c;
        compared++;
        if (n_xfer > 3 || b2.value !== exp2[n_xfer & 3] || b2.i !== 1'(n_xfer / 2) || b2.j !== 1'(n_xfer % 2)) begin
          mismatched++;
          $display("FAIL n2_elem%0d: got value=%0h i=%0d j=%0d expected value=%0h i=%0d j=%0d",
                   n_xfer, b2.value, b2.i, b2.j, exp2[n_xfer & 3], (n_xfer / 2) & 1, n_xfer % 2);
        end
        n_xfer++;
      end
      if (b2.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; di = b2.i; dj = b2.j; end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      tick();
    end
    b2.value_ack = 1'b0;
    compared++; if (first_stb != 2) begin mismatched++; $display("FAIL n2_first_stb_cycle: got %0d expected 2", first_stb); end
    compared++; if (n_xfer != 4) begin mismatched++; $display("FAIL n2_xfer_count: got %0d expected 4", n_xfer); end
    compared++; if (done_cyc != 9) begin mismatched++; $display("FAIL n2_done_cycle: got %0d expected 9", done_cyc); end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL n2_done_pulses: got %0d expected 1", done_cnt); end
    compared++; if (di !== 1'b1 || dj !== 1'b1) begin mismatched++; $display("FAIL n2_final_ij: got %0d,%0d expected 1,1", di, dj); end
  endtask

  initial begin
    exp2[0] = 32'h1234_0000;
    exp2[1] = 32'h0000_5678;
    exp2[2] = 32'h9ABC_DEF0;
    exp2[3] = 32'h0F0F_F0F0;
    test_reset();
    load8();
    test_stream_acked();
    test_stalls();
    test_ignore();
    test_abort();
    test_write_start();
    test_n2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
